// File: rtl/apb_master.sv
// rtl/apb_master.sv - APB initiator turning single-beat commands into GPIO/UART APB transfers
// Optional build macro: APB_MASTER_TIMEOUT_EN aborts ACCESS after TIMEOUT wait cycles.
module apb_master #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       PSEL1,
  output logic       PSEL2,
  output logic       PENABLE,
  output logic [7:0] PADDR,
  output logic       PWRITE,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       PREADY
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t     state_q;
  logic       psel1_q, psel2_q, penable_q;
  logic       rsp_valid_q, rsp_err_q, pwrite_q;
  logic [7:0] paddr_q, pwdata_q, rsp_rdata_q;
  logic       accept;
  logic       timeout_hit;

  // RESP accepts like IDLE so back-to-back transfers cost three cycles
  assign cmd_ready = (state_q == IDLE) || (state_q == RESP);
  assign accept    = cmd_valid && cmd_ready;

`ifdef APB_MASTER_TIMEOUT_EN
  logic [7:0] wait_cnt_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wait_cnt_q <= 8'd0;
    end else if (state_q == SETUP) begin
      wait_cnt_q <= 8'd0;
    end else if (state_q == ACCESS && !PREADY) begin
      wait_cnt_q <= wait_cnt_q + 8'd1;
    end
  end

  assign timeout_hit = (wait_cnt_q == 8'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      psel1_q     <= 1'b0;
      psel2_q     <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 8'd0;
      paddr_q     <= 8'd0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= 8'd0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE, RESP: begin
          if (accept) begin
            paddr_q  <= cmd_addr;
            pwrite_q <= cmd_write;
            pwdata_q <= cmd_wdata;
            if (cmd_addr[7]) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= 8'd0;
            end else begin
              state_q <= SETUP;
              psel1_q <= ~cmd_addr[6];
              psel2_q <= cmd_addr[6];
            end
          end else begin
            state_q <= IDLE;
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
        end
        ACCESS: begin
          if (PREADY || timeout_hit) begin
            state_q     <= RESP;
            psel1_q     <= 1'b0;
            psel2_q     <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= ~PREADY;
            rsp_rdata_q <= (PREADY && !pwrite_q) ? PRDATA : 8'd0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign PSEL1     = psel1_q;
  assign PSEL2     = psel2_q;
  assign PENABLE   = penable_q;
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - self-checking bench for apb_master against a transaction-level model
module tb_apb_master;

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_addr = 8'd0;
  logic [7:0] cmd_wdata = 8'd0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       PSEL1, PSEL2, PENABLE, PWRITE;
  logic [7:0] PADDR, PWDATA;
  logic [7:0] PRDATA = 8'd0;
  logic       PREADY = 1'b0;

  int tests = 0;
  int fails = 0;

  apb_master #(.TIMEOUT(4)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    @(negedge PCLK);
  endtask

  // One command end to end; expectations come from the address map and wait count only
  task automatic do_txn(input logic w, input logic [7:0] a, input logic [7:0] d,
                        input int waits, input logic [7:0] rd);
    logic       mapped, sel1, sel2, exp_err;
    logic [7:0] exp_rdata;
    int         lat;
    mapped    = (a[7] == 1'b0);
    sel1      = mapped && !a[6];
    sel2      = mapped && a[6];
    exp_err   = !mapped;
    exp_rdata = (mapped && !w) ? rd : 8'd0;
    lat       = mapped ? 3 + waits : 1;

    check("ready_before_cmd", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    PREADY = 1'($urandom); PRDATA = 8'($urandom);
    step();
    cmd_valid = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      logic resp;
      resp = (c == lat);
      check("psel1", PSEL1, sel1 && !resp);
      check("psel2", PSEL2, sel2 && !resp);
      check("penable", PENABLE, (c >= 2) && !resp);
      check("rsp_valid", rsp_valid, resp);
      check("cmd_ready", cmd_ready, resp);
      if (c == 1) begin
        check("paddr", PADDR, a);
        check("pwrite", PWRITE, w);
        check("pwdata", PWDATA, d);
      end
      if (resp) begin
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("rsp_err", rsp_err, exp_err);
      end
      PREADY = (c == 1 || resp) ? 1'($urandom) : (c == lat - 1);
      PRDATA = (c == lat - 1) ? rd : 8'($urandom);
      step();
    end
    check("idle_rsp_valid", rsp_valid, 1'b0);
    check("idle_rdata_hold", rsp_rdata, exp_rdata);
    check("idle_err_hold", rsp_err, exp_err);
    check("idle_paddr_hold", PADDR, a);
    check("idle_no_sel", PSEL1 | PSEL2 | PENABLE, 1'b0);
  endtask

  initial begin
    logic [5:0] b2b_p1, b2b_p2, b2b_en, b2b_rv;
    int         rsp_seen;

    #1;
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 8'd0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_psel", {PSEL1, PSEL2, PENABLE}, 3'b000);
    check("rst_paddr", PADDR, 8'd0);
    check("rst_pwrite", PWRITE, 1'b0);
    check("rst_pwdata", PWDATA, 8'd0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    step();

    do_txn(1'b1, 8'h41, 8'h5A, 0, 8'h00);
    do_txn(1'b0, 8'h02, 8'h00, 2, 8'hC3);
    do_txn(1'b0, 8'h80, 8'h11, 0, 8'h77);
    do_txn(1'b1, 8'hC5, 8'h22, 0, 8'h00);

    for (int i = 0; i < 24; i++) begin
      do_txn(1'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 8'($urandom));
    end

    // Back-to-back writes with cmd_valid held: second accept lands in the first RESP cycle
    b2b_p1 = 6'b000011; b2b_p2 = 6'b011000; b2b_en = 6'b010010; b2b_rv = 6'b100100;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h00; cmd_wdata = 8'hA1; PREADY = 1'b1;
    step();
    cmd_addr = 8'h40; cmd_wdata = 8'hB2;
    for (int c = 1; c <= 6; c++) begin
      check("b2b_psel1", PSEL1, b2b_p1[c-1]);
      check("b2b_psel2", PSEL2, b2b_p2[c-1]);
      check("b2b_penable", PENABLE, b2b_en[c-1]);
      check("b2b_rsp_valid", rsp_valid, b2b_rv[c-1]);
      check("b2b_no_overlap", PSEL1 & PSEL2, 1'b0);
      if (c == 1) check("b2b_paddr1", PADDR, 8'h00);
      if (c == 4) check("b2b_paddr2", PADDR, 8'h40);
      if (c == 3 || c == 6) check("b2b_err", rsp_err, 1'b0);
      step();
      if (c == 3) cmd_valid = 1'b0;
    end
    check("b2b_idle", rsp_valid, 1'b0);

    // Reset in the middle of a stalled ACCESS
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h41; cmd_wdata = 8'h5A; PREADY = 1'b0;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    check("stall_psel2", PSEL2, 1'b1);
    check("stall_penable", PENABLE, 1'b1);
    PRESETn = 1'b0;
    #1;
    check("mid_rst_psel2", PSEL2, 1'b0);
    check("mid_rst_penable", PENABLE, 1'b0);
    check("mid_rst_rsp_valid", rsp_valid, 1'b0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    check("post_rst_ready", cmd_ready, 1'b1);
    step();
    check("post_rst_no_rsp", rsp_valid, 1'b0);

    // PREADY stuck low
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h03; PREADY = 1'b0; PRDATA = 8'hFF;
    step();
    cmd_valid = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
    for (int c = 1; c <= 6; c++) begin
      check("to_rsp_valid", rsp_valid, c == 6);
      check("to_psel1", PSEL1, c < 6);
      if (c == 6) begin
        check("to_err", rsp_err, 1'b1);
        check("to_rdata", rsp_rdata, 8'd0);
        check("to_penable", PENABLE, 1'b0);
      end
      step();
    end
`else
    rsp_seen = 0;
    for (int c = 1; c <= 100; c++) begin
      if (rsp_valid === 1'b1) rsp_seen++;
      step();
    end
    check("stuck_no_rsp", rsp_seen, 0);
    check("stuck_penable", PENABLE, 1'b1);
    check("stuck_psel1", PSEL1, 1'b1);
    PRESETn = 1'b0;
    step();
    PRESETn = 1'b1;
    step();
`endif
    check("final_ready", cmd_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
